// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
//
// Exception / interrupt sequencer for the multicycle MIPS core. It sits right
// upstream of the EPC, Cause and Status registers and decides when, and in what
// order, those registers are written on exception entry. It also redirects the
// PC to the exception vector, and on ERET it redirects the PC to EPC.
//
// Sources, highest priority first:
//   overflow (ExcCode 12) > reserved instruction (10) > syscall (8) > interrupt (0)
//
// Sequence for one exception:
//   IDLE   : a source is seen. The code, the EPC word address and the Cause image
//            are registered, and stall is raised.
//   SAVE   : EPCWrite, CWrite and srst fire together. srst clears Status.IE, so
//            no interrupt can nest until ERET.
//   VECTOR : exc_take fires. The core loads the PC with exc_vector.
//
// Optional build macro:
//   EXC_IRQ_SYNC_EN
//     Defined   : hw_int goes through a SYNC_STAGES-deep flop chain per bit
//                 before it forms ip.
//     Undefined : ip = hw_int directly, so hw_int must already be synchronous
//                 to Clk.
//
// Parameters:
//   VECTOR_ADDR  exception entry address, driven on exc_vector
//   SYNC_STAGES  depth of the hw_int synchronizer (EXC_IRQ_SYNC_EN builds only)
//
// Ports:
//   Clk             in   clock; all state changes on the rising edge
//   Reset           in   synchronous reset, active low
//   hw_int[5:0]     in   hardware interrupt levels
//   exc_ov          in   1-cycle pulse: ALU overflow
//   exc_ri          in   1-cycle pulse: reserved instruction
//   exc_sys         in   1-cycle pulse: SYSCALL
//   eret            in   1-cycle pulse: ERET executing (only with instr_boundary)
//   instr_boundary  in   core is in fetch; an interrupt may be taken
//   cur_pc[31:0]    in   PC of the instruction currently executing
//   status[31:0]    in   Status register; [0]=IE, [15:10]=IM[5:0]
//   EPCWrite        out  EPC write enable
//   epc_data[29:0]  out  EPC write data (word address)
//   CWrite          out  Cause write enable
//   cause_data[31:0] out Cause write data (IP in [15:10], ExcCode in [6:2])
//   srst            out  clear Status[0]
//   sset            out  set Status[0]
//   exc_take        out  1-cycle pulse: load PC with exc_vector
//   exc_vector[31:0] out constant VECTOR_ADDR
//   eret_take       out  1-cycle pulse: load PC from EPC
//   stall           out  core must hold its state this cycle
//   dbg_state[1:0]  out  current sequencer state (IDLE=0, SAVE=1, VECTOR=2)
// -----------------------------------------------------------------------------
module exc_ctrl #(
  parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  hw_int,
  input  logic        exc_ov,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        eret,
  input  logic        instr_boundary,
  input  logic [31:0] cur_pc,
  input  logic [31:0] status,
  output logic        EPCWrite,
  output logic [29:0] epc_data,
  output logic        CWrite,
  output logic [31:0] cause_data,
  output logic        srst,
  output logic        sset,
  output logic        exc_take,
  output logic [31:0] exc_vector,
  output logic        eret_take,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    VECTOR = 2'd2
  } state_t;

  localparam logic [4:0] CODE_OV  = 5'd12;
  localparam logic [4:0] CODE_RI  = 5'd10;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_INT = 5'd0;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  pend_q;    // sticky {ov, ri, sys}
  logic [29:0] epc_q;
  logic [31:0] cause_q;

  logic [5:0]  ip;
  logic [2:0]  src;       // pulses merged with the sticky latch
  logic        irq_req;
  logic [4:0]  code;
  logic        take;      // exception accepted this cycle (IDLE -> SAVE)

  // ---------------------------------------------------------------------------
  // Interrupt pending bits
  // ---------------------------------------------------------------------------
`ifdef EXC_IRQ_SYNC_EN
  logic [5:0] sync_q [SYNC_STAGES];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ip = sync_q[SYNC_STAGES-1];
`else
  assign ip = hw_int;

  // The synchronizer depth only matters when the chain is built.
  logic unused_sync_depth;
  assign unused_sync_depth = (SYNC_STAGES > 0);
`endif

  // Only IE, IM and the word part of the PC are meaningful here.
  logic unused_bits;
  assign unused_bits = ^{status[31:16], status[9:1], cur_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Source qualification and priority
  // ---------------------------------------------------------------------------
  // A pulse is honoured in the same cycle it arrives, together with anything
  // latched while a previous sequence was still running.
  assign src     = {exc_ov, exc_ri, exc_sys} | pend_q;
  assign irq_req = status[0] & (|(ip & status[15:10])) & instr_boundary;

  always_comb begin
    code = CODE_INT;
    if (src[2]) begin
      code = CODE_OV;
    end else if (src[1]) begin
      code = CODE_RI;
    end else if (src[0]) begin
      code = CODE_SYS;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and outputs
  // ---------------------------------------------------------------------------
  // While Reset is low every enable and pulse stays quiet. This means a reset
  // that lands mid-sequence never produces a partial register write.
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    stall     = 1'b0;
    EPCWrite  = 1'b0;
    CWrite    = 1'b0;
    srst      = 1'b0;
    sset      = 1'b0;
    exc_take  = 1'b0;
    eret_take = 1'b0;

    if (Reset) begin
      unique case (state_q)
        IDLE: begin
          if ((|src) || irq_req) begin
            // Exceptions win over a coincident ERET; the ERET is dropped.
            take    = 1'b1;
            stall   = 1'b1;
            state_d = SAVE;
          end else if (eret) begin
            sset      = 1'b1;
            eret_take = 1'b1;
          end
        end
        SAVE: begin
          EPCWrite = 1'b1;
          CWrite   = 1'b1;
          srst     = 1'b1;
          stall    = 1'b1;
          state_d  = VECTOR;
        end
        VECTOR: begin
          exc_take = 1'b1;
          stall    = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, pending latch and captured EPC / Cause images
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        // Entering SAVE clears the latch. Lower-priority sources that arrived
        // together with the winning one are discarded here on purpose.
        pend_q  <= '0;
        epc_q   <= cur_pc[31:2];
        cause_q <= {16'b0, ip, 2'b0, 1'b0, code, 2'b0};
      end else begin
        // Only reachable with pulses during SAVE/VECTOR. An IDLE pulse always
        // causes take in the same cycle.
        pend_q <= pend_q | {exc_ov, exc_ri, exc_sys};
      end
    end
  end

  assign epc_data   = epc_q;
  assign cause_data = cause_q;
  assign exc_vector = VECTOR_ADDR;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl
//
// Bench for exc_ctrl. Directed steps walk through the exception entry, priority,
// interrupt gating, ERET and reset-abort scenarios. A long randomized run then
// follows. A behavioural model judges every cycle: it tracks the cycle count
// since an exception was detected, a set of pending source flags, and the
// interrupt history. Expected EPC/Cause images are queued at detection and
// consumed in the register-write cycle.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

`ifdef EXC_IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  localparam logic [31:0] VEC = 32'h8000_0180;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        Clk;
  logic        Reset;
  logic [5:0]  hw_int;
  logic        exc_ov, exc_ri, exc_sys, eret, instr_boundary;
  logic [31:0] cur_pc, status;
  logic        EPCWrite, CWrite, srst, sset, exc_take, eret_take, stall;
  logic [29:0] epc_data;
  logic [31:0] cause_data, exc_vector;
  logic [1:0]  dbg_state;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  exc_ctrl dut (
    .Clk(Clk), .Reset(Reset), .hw_int(hw_int),
    .exc_ov(exc_ov), .exc_ri(exc_ri), .exc_sys(exc_sys), .eret(eret),
    .instr_boundary(instr_boundary), .cur_pc(cur_pc), .status(status),
    .EPCWrite(EPCWrite), .epc_data(epc_data), .CWrite(CWrite),
    .cause_data(cause_data), .srst(srst), .sset(sset), .exc_take(exc_take),
    .exc_vector(exc_vector), .eret_take(eret_take), .stall(stall),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];        // {epc, cause} pairs awaiting the write cycle
  int          since_det = 0;   // 0: no sequence, 1: write cycle, 2: vector cycle
  logic [2:0]  pend_m = '0;     // {ov, ri, sys}
  logic [29:0] epc_m = '0;
  logic [31:0] cause_m = '0;
  logic [5:0]  hw_hist[$];
  int          code_tab[3] = '{8, 10, 12};  // indexed like {sys, ri, ov}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [5:0] ipm;
    logic [2:0] act;
    logic       det;
    int         code;
    logic       e_stall, e_epcw, e_cw, e_srst, e_sset, e_take, e_etake;
    #1;
    ipm  = (IRQ_LAT == 0) ? hw_int : hw_hist[0];
    act  = {exc_ov, exc_ri, exc_sys} | pend_m;
    code = 0;
    for (int k = 0; k < 3; k++) begin
      if (act[k]) code = code_tab[k];
    end
    det = 1'b0;
    {e_stall, e_epcw, e_cw, e_srst, e_sset, e_take, e_etake} = '0;
    if (Reset) begin
      if (since_det == 0) begin
        det = (act != 3'b000) ||
              (status[0] && ((ipm & status[15:10]) != 6'd0) && instr_boundary);
        e_stall = det;
        e_sset  = !det && eret;
        e_etake = !det && eret;
      end else if (since_det == 1) begin
        {e_stall, e_epcw, e_cw, e_srst} = 4'hF;
      end else begin
        {e_stall, e_take} = 2'b11;
      end
    end

    chk("stall", stall, e_stall);
    chk("EPCWrite", EPCWrite, e_epcw);
    chk("CWrite", CWrite, e_cw);
    chk("srst", srst, e_srst);
    chk("sset", sset, e_sset);
    chk("exc_take", exc_take, e_take);
    chk("eret_take", eret_take, e_etake);
    chk("exc_vector", exc_vector, VEC);
    if (Reset && since_det == 1 && exp_q.size() >= 2) begin
      chk("epc_write", {2'b0, epc_data}, exp_q.pop_front());
      chk("cause_write", cause_data, exp_q.pop_front());
    end else begin
      chk("epc_hold", {2'b0, epc_data}, {2'b0, epc_m});
      chk("cause_hold", cause_data, cause_m);
    end

    // Advance the model across the coming rising edge.
    if (!Reset) begin
      since_det = 0;
      pend_m    = '0;
      epc_m     = '0;
      cause_m   = '0;
      exp_q.delete();
      hw_hist.delete();
      for (int k = 0; k < IRQ_LAT; k++) hw_hist.push_back(6'd0);
    end else begin
      if (since_det == 0) begin
        if (det) begin
          since_det = 1;
          pend_m    = '0;
          epc_m     = cur_pc[31:2];
          cause_m   = 32'(ipm) * 32'd1024 + 32'(code) * 32'd4;
          exp_q.push_back({2'b0, epc_m});
          exp_q.push_back(cause_m);
        end
      end else begin
        pend_m    = pend_m | {exc_ov, exc_ri, exc_sys};
        since_det = (since_det == 1) ? 2 : 0;
      end
      if (IRQ_LAT > 0) begin
        hw_hist.push_back(hw_int);
        void'(hw_hist.pop_front());
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic [2:0] exc, input logic er,
                       input logic ib, input logic [5:0] hw,
                       input logic [31:0] pc, input logic [31:0] st);
    @(negedge Clk);
    Reset          = rst;
    {exc_ov, exc_ri, exc_sys} = exc;
    eret           = er;
    instr_boundary = ib;
    hw_int         = hw;
    cur_pc         = pc;
    status         = st;
    check_cycle();
  endtask

  task automatic idle(input int n, input logic [31:0] st);
    for (int i = 0; i < n; i++) drive(1'b1, 3'b000, 1'b0, 1'b1, 6'd0, 32'h0040_0100, st);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    Reset = 1'b0; exc_ov = 1'b1; exc_ri = 1'b0; exc_sys = 1'b0; eret = 1'b0;
    instr_boundary = 1'b0; hw_int = '0; cur_pc = '0; status = '0;
    for (int k = 0; k < IRQ_LAT; k++) hw_hist.push_back(6'd0);

    // Reset held with exc_ov high: nothing is written and nothing remains.
    drive(1'b0, 3'b100, 1'b0, 1'b0, 6'd0, 32'h0040_0010, 32'h0);
    drive(1'b0, 3'b100, 1'b0, 1'b0, 6'd0, 32'h0040_0010, 32'h0);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0010, 32'h0);
    chk("rst_epcwrite", EPCWrite, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_epc", {2'b0, epc_data}, 32'h0);
    idle(2, 32'h0);

    // Overflow entry.
    drive(1'b1, 3'b100, 1'b0, 1'b0, 6'd0, 32'h0040_0010, 32'h0);
    chk("ov_detect_stall", stall, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0014, 32'h0);
    chk("ov_save_epcw", EPCWrite, 1'b1);
    chk("ov_save_epc", {2'b0, epc_data}, 32'h0010_0004);
    chk("ov_save_code", {27'b0, cause_data[6:2]}, 32'd12);
    chk("ov_save_srst", srst, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0014, 32'h0);
    chk("ov_vec_take", exc_take, 1'b1);
    chk("ov_vec_addr", exc_vector, 32'h8000_0180);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0014, 32'h0);
    chk("ov_after_stall", stall, 1'b0);

    // RI and SYS together: RI reported, SYS dropped.
    drive(1'b1, 3'b011, 1'b0, 1'b0, 6'd0, 32'h0040_0200, 32'h0);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0200, 32'h0);
    chk("risys_code", {27'b0, cause_data[6:2]}, 32'd10);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0200, 32'h0);
    idle(3, 32'h0);
    chk("risys_no_second", stall, 1'b0);

    // Interrupt on IP0 with IE=1, IM0=1.
    for (int i = 0; i < IRQ_LAT; i++) begin
      drive(1'b1, 3'b000, 1'b0, 1'b1, 6'b000001, 32'h0040_0300, 32'h0000_0401);
      chk("irq_sync_wait", stall, 1'b0);
    end
    drive(1'b1, 3'b000, 1'b0, 1'b1, 6'b000001, 32'h0040_0300, 32'h0000_0401);
    chk("irq_detect", stall, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b1, 6'b000000, 32'h0040_0304, 32'h0000_0400);
    chk("irq_save_cause", cause_data, 32'h0000_0400);
    chk("irq_save_epcw", EPCWrite, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b1, 6'b000000, 32'h0040_0304, 32'h0000_0400);
    idle(IRQ_LAT + 2, 32'h0000_0400);

    // Same interrupt with IE=0: ignored.
    for (int i = 0; i < IRQ_LAT + 4; i++) begin
      drive(1'b1, 3'b000, 1'b0, 1'b1, 6'b000001, 32'h0040_0400, 32'h0000_0400);
      chk("irq_masked", stall, 1'b0);
    end
    idle(IRQ_LAT + 2, 32'h0000_0400);

    // ERET alone.
    drive(1'b1, 3'b000, 1'b1, 1'b1, 6'd0, 32'h8000_0190, 32'h0000_0400);
    chk("eret_sset", sset, 1'b1);
    chk("eret_take", eret_take, 1'b1);
    chk("eret_stall", stall, 1'b0);
    drive(1'b1, 3'b000, 1'b0, 1'b1, 6'd0, 32'h0040_0500, 32'h0000_0401);
    chk("eret_one_cycle", eret_take, 1'b0);

    // ERET together with SYSCALL: exception wins.
    drive(1'b1, 3'b001, 1'b1, 1'b1, 6'd0, 32'h0040_0600, 32'h0000_0000);
    chk("eret_sys_stall", stall, 1'b1);
    chk("eret_sys_sset", sset, 1'b0);
    chk("eret_sys_etake", eret_take, 1'b0);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0604, 32'h0);
    chk("eret_sys_code", {27'b0, cause_data[6:2]}, 32'd8);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0604, 32'h0);
    idle(2, 32'h0);

    // Reset during SAVE, with an RI pulse that would otherwise be latched.
    drive(1'b1, 3'b100, 1'b0, 1'b0, 6'd0, 32'h0040_0700, 32'h0);
    drive(1'b0, 3'b010, 1'b0, 1'b0, 6'd0, 32'h0040_0704, 32'h0);
    chk("rsave_no_write", EPCWrite, 1'b0);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0704, 32'h0);
    chk("rsave_no_take", exc_take, 1'b0);
    chk("rsave_no_pending", stall, 1'b0);
    chk("rsave_epc_clear", {2'b0, epc_data}, 32'h0);
    idle(3, 32'h0);

    // Pulses during a running sequence are latched and taken afterwards.
    drive(1'b1, 3'b001, 1'b0, 1'b0, 6'd0, 32'h0040_0800, 32'h0);
    drive(1'b1, 3'b010, 1'b0, 1'b0, 6'd0, 32'h0040_0804, 32'h0);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_0808, 32'h0);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 32'h0040_080C, 32'h0);
    chk("latched_retake", stall, 1'b1);
    idle(4, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic       rst, ib, er;
      logic [2:0] ex;
      logic [5:0] hw;
      rst = ($urandom_range(0, 49) != 0);
      ex  = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0)};
      ib  = 1'($urandom_range(0, 1));
      er  = ib && ($urandom_range(0, 4) == 0);
      hw  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      drive(rst, ex, er, ib, hw, $urandom, $urandom);
    end
    idle(4, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
